// File: rtl/cordic_nco_pkg.sv
// Shared types and helpers for the multi-channel CORDIC NCO scheduler.
package cordic_nco_pkg;

  // Scheduler FSM: idle between ticks, one issue slot per cycle while in ISSUE.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } nco_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned nch);
    int unsigned w;
    if (nch > 32'd1) begin
      w = int'($clog2(nch));
    end else begin
      w = 32'd1;
    end
    return w;
  endfunction

  // CORDIC x start value that pre-compensates the core gain (~1.647) while
  // leaving (DWIDTH-1)/2 LSBs of headroom. Integer form of num / 1.647,
  // truncated toward zero.
  function automatic longint unsigned cordic_coef(input int unsigned dwidth);
    longint unsigned num;
    num = (64'd1 << (dwidth - 32'd1)) - 64'((dwidth - 32'd1) / 32'd2);
    return (num * 64'd1000) / 64'd1647;
  endfunction

endpackage

// File: rtl/cordic_tag_pipe.sv
// Delay line that carries {valid, channel} alongside the CORDIC core so each
// returning cos/sin pair can be labelled with the channel that issued it.
module cordic_tag_pipe #(
  parameter int DEPTH = 17,
  parameter int CHW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [CHW-1:0] i_ch,
  output logic           o_valid,
  output logic [CHW-1:0] o_ch
);

  logic           r_valid [DEPTH];
  logic [CHW-1:0] r_ch    [DEPTH];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ch[i]    <= {CHW{1'b0}};
      end
    end else begin
      r_valid[0] <= i_valid;
      r_ch[0]    <= i_ch;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_ch[i]    <= r_ch[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_ch    = r_ch[DEPTH-1];

endmodule

// File: rtl/cordic_nco_sched.sv
// Round-robin scheduler that time-shares one pipelined CORDIC rotator among
// NCH phase-accumulator NCO channels. Each tick issues one angle per channel
// (disabled channels still consume their slot) and tags it so the result
// returns labelled with its channel.
module cordic_nco_sched
  import cordic_nco_pkg::*;
#(
  parameter  int NCH        = 4,
  parameter  int DWIDTH     = 16,
  parameter  int PWIDTH     = 32,
  parameter  int CORDIC_LAT = 16,
  localparam int CHW        = int'(ch_width(NCH))
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     cfg_we,
  input  logic [CHW-1:0]           cfg_ch,
  input  logic [PWIDTH-1:0]        cfg_step,
  input  logic                     cfg_en,
  input  logic                     cfg_phase_clr,
  output logic [PWIDTH-1:0]        cor_angle,
  output logic [DWIDTH-1:0]        cor_x_start,
  output logic [DWIDTH-1:0]        cor_y_start,
  input  logic signed [DWIDTH-1:0] cor_cos,
  input  logic signed [DWIDTH-1:0] cor_sin,
  output logic                     out_valid,
  output logic [CHW-1:0]           out_ch,
  output logic signed [DWIDTH-1:0] out_cos,
  output logic signed [DWIDTH-1:0] out_sin,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [DWIDTH-1:0] X_START = DWIDTH'(cordic_coef(DWIDTH));
  localparam logic [CHW-1:0]    K_LAST  = CHW'(NCH - 1);
  localparam int                TAG_DEPTH = CORDIC_LAT + 1;

  // Channel register file
  logic [PWIDTH-1:0] r_phase [NCH];
  logic [PWIDTH-1:0] r_step  [NCH];
  logic              r_en    [NCH];

  // Scheduler state
  nco_state_t        r_state;
  logic [CHW-1:0]    r_k;
  logic [PWIDTH-1:0] r_angle;
  logic              r_busy;
  logic              r_overrun;

  // Result registers
  logic                     r_out_valid;
  logic [CHW-1:0]           r_out_ch;
  logic signed [DWIDTH-1:0] r_out_cos;
  logic signed [DWIDTH-1:0] r_out_sin;

  // Combinational control
  nco_state_t     w_state_nxt;
  logic [CHW-1:0] w_k_nxt;
  logic           w_issue;
  logic [CHW-1:0] w_idx;
  logic           w_tick_drop;
  logic           w_tag_in_valid;
  logic [NCH-1:0] w_cfg_hit;
  logic           w_tag_valid;
  logic [CHW-1:0] w_tag_ch;

  // Next-state logic. A slot fires on the edge that closes its cycle, so the
  // slot for channel 0 fires on the tick edge itself and r_k names the
  // channel whose angle is currently on cor_angle.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_issue     = 1'b0;
    w_idx       = {CHW{1'b0}};
    w_tick_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (tick) begin
          w_state_nxt = ISSUE;
          w_k_nxt     = {CHW{1'b0}};
          w_issue     = 1'b1;
          w_idx       = {CHW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        // Any tick during a round, including its last cycle, is dropped.
        w_tick_drop = tick;
        if (r_k == K_LAST) begin
          w_state_nxt = IDLE;
          w_k_nxt     = {CHW{1'b0}};
        end else begin
          w_state_nxt = ISSUE;
          w_k_nxt     = r_k + CHW'(1'b1);
          w_issue     = 1'b1;
          w_idx       = r_k + CHW'(1'b1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_k_nxt     = {CHW{1'b0}};
      end
    endcase
  end

  // Decode config-write hits and the tag entering the delay line.
  always_comb begin
    w_cfg_hit = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      w_cfg_hit[i] = cfg_we && (cfg_ch == CHW'(i));
    end
    if (w_issue) begin
      w_tag_in_valid = r_en[w_idx];
    end else begin
      w_tag_in_valid = 1'b0;
    end
  end

  // Register file: writes land next edge; a same-edge advance reads the old
  // step/enable, and a phase clear wins over that advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_phase[i] <= {PWIDTH{1'b0}};
        r_step[i]  <= {PWIDTH{1'b0}};
        r_en[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cfg_hit[i] && cfg_phase_clr) begin
          r_phase[i] <= {PWIDTH{1'b0}};
        end else if (w_issue && (w_idx == CHW'(i)) && r_en[i]) begin
          r_phase[i] <= r_phase[i] + r_step[i];
        end else begin
          r_phase[i] <= r_phase[i];
        end
        if (w_cfg_hit[i]) begin
          r_step[i] <= cfg_step;
          r_en[i]   <= cfg_en;
        end else begin
          r_step[i] <= r_step[i];
          r_en[i]   <= r_en[i];
        end
      end
    end
  end

  // FSM state, issued angle, busy flag and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= {CHW{1'b0}};
      r_angle   <= {PWIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_busy    <= (w_state_nxt == ISSUE);
      r_overrun <= r_overrun | w_tick_drop;
      if (w_issue) begin
        r_angle <= r_phase[w_idx];
      end else begin
        r_angle <= r_angle;
      end
    end
  end

  cordic_tag_pipe #(
    .DEPTH (TAG_DEPTH),
    .CHW   (CHW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_tag_in_valid),
    .i_ch    (w_idx),
    .o_valid (w_tag_valid),
    .o_ch    (w_tag_ch)
  );

  // Capture core results aligned with their tag; hold them between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= {CHW{1'b0}};
      r_out_cos   <= {DWIDTH{1'b0}};
      r_out_sin   <= {DWIDTH{1'b0}};
    end else begin
      r_out_valid <= w_tag_valid;
      if (w_tag_valid) begin
        r_out_ch  <= w_tag_ch;
        r_out_cos <= cor_cos;
        r_out_sin <= cor_sin;
      end else begin
        r_out_ch  <= r_out_ch;
        r_out_cos <= r_out_cos;
        r_out_sin <= r_out_sin;
      end
    end
  end

  assign cor_angle   = r_angle;
  assign cor_x_start = X_START;
  assign cor_y_start = {DWIDTH{1'b0}};
  assign out_valid   = r_out_valid;
  assign out_ch      = r_out_ch;
  assign out_cos     = r_out_cos;
  assign out_sin     = r_out_sin;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_cordic_nco_sched.sv
// Scoreboard bench for cordic_nco_sched with a behavioural stand-in for the
// CORDIC core (fixed-latency mapping of angle to a recognisable cos/sin).
module tb_cordic_nco_sched;

  localparam int NCH = 4;
  localparam int DWIDTH = 16;
  localparam int PWIDTH = 32;
  localparam int LAT = 16;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic              cfg_we = 1'b0;
  logic [CHW-1:0]    cfg_ch = 2'd0;
  logic [PWIDTH-1:0] cfg_step = 32'd0;
  logic              cfg_en = 1'b0;
  logic              cfg_phase_clr = 1'b0;
  logic [PWIDTH-1:0] cor_angle;
  logic [DWIDTH-1:0] cor_x_start, cor_y_start, cor_cos, cor_sin;
  logic              out_valid, busy, overrun;
  logic [CHW-1:0]    out_ch;
  logic [DWIDTH-1:0] out_cos, out_sin;

  typedef struct {
    logic [CHW-1:0]    ch;
    logic [DWIDTH-1:0] cs;
    logic [DWIDTH-1:0] sn;
    int                due;
  } sb_t;

  sb_t               sb[$];
  int                cyc = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  int                n_out = 0;
  logic [PWIDTH-1:0] m_phase [NCH];
  logic [PWIDTH-1:0] m_step  [NCH];
  logic              m_en    [NCH];
  logic [PWIDTH-1:0] hist    [LAT];

  cordic_nco_sched #(.NCH(NCH), .DWIDTH(DWIDTH), .PWIDTH(PWIDTH), .CORDIC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_step(cfg_step), .cfg_en(cfg_en), .cfg_phase_clr(cfg_phase_clr),
    .cor_angle(cor_angle), .cor_x_start(cor_x_start), .cor_y_start(cor_y_start),
    .cor_cos(cor_cos), .cor_sin(cor_sin), .out_valid(out_valid), .out_ch(out_ch),
    .out_cos(out_cos), .out_sin(out_sin), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DWIDTH-1:0] core_cos(input logic [PWIDTH-1:0] a);
    return a[31:16];
  endfunction

  function automatic logic [DWIDTH-1:0] core_sin(input logic [PWIDTH-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Core stand-in: result for the angle seen LAT cycles earlier.
  always @(posedge clk) begin
    hist[0] <= cor_angle;
    for (int j = 1; j < LAT; j++) hist[j] <= hist[j-1];
  end
  assign cor_cos = core_cos(hist[LAT-1]);
  assign cor_sin = core_sin(hist[LAT-1]);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Output monitor: pops the scoreboard on every out_valid.
  initial begin
    sb_t               e;
    logic              prev_valid = 1'b0;
    logic [DWIDTH-1:0] last_cos = 16'd0;
    logic [DWIDTH-1:0] last_sin = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_valid = 1'b0;
      end else begin
        if (out_valid) begin
          n_out++;
          if (sb.size() == 0) begin
            check_eq("spurious_valid", {63'd0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            check_eq("out_ch", out_ch, e.ch);
            check_eq("out_cos", out_cos, e.cs);
            check_eq("out_sin", out_sin, e.sn);
            check_eq("out_cycle", cyc, e.due);
            last_cos = e.cs;
            last_sin = e.sn;
          end
        end else if (prev_valid) begin
          check_eq("hold_cos", out_cos, last_cos);
          check_eq("hold_sin", out_sin, last_sin);
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_phase[i] = 32'd0;
      m_step[i]  = 32'd0;
      m_en[i]    = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] step, input logic en, input logic clr);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_step = step; cfg_en = en; cfg_phase_clr = clr;
    @(negedge clk);
    cfg_we = 1'b0; cfg_phase_clr = 1'b0;
    m_step[ch] = step;
    m_en[ch] = en;
    if (clr) m_phase[ch] = 32'd0;
  endtask

  // One issue round from a tick driven now (at a negedge). Optionally a second
  // tick at loop index extra_at, and a config write to channel cfg_k during
  // that channel's slot cycle (same edge as its phase advance).
  task automatic do_round(input int extra_at, input int cfg_k, input logic [31:0] c_step, input logic c_clr);
    int t;
    t = cyc;
    tick = 1'b1;
    if (cfg_k == 0) begin
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_step = c_step; cfg_en = 1'b1; cfg_phase_clr = c_clr;
    end
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      tick = (k == extra_at);
      if (k + 1 == cfg_k) begin
        cfg_we = 1'b1; cfg_ch = 2'(k + 1); cfg_step = c_step; cfg_en = 1'b1; cfg_phase_clr = c_clr;
      end else begin
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
      end
      check_eq($sformatf("angle_ch%0d", k), cor_angle, m_phase[k]);
      check_eq("busy_round", {63'd0, busy}, 64'd1);
      if (m_en[k]) begin
        sb.push_back('{ch: 2'(k), cs: core_cos(m_phase[k]), sn: core_sin(m_phase[k]), due: t + 2 + k + LAT});
        m_phase[k] = m_phase[k] + m_step[k];
      end
      if (k == cfg_k) begin
        if (c_clr) m_phase[k] = 32'd0;
        m_step[k] = c_step;
        m_en[k] = 1'b1;
      end
    end
    @(negedge clk);
    tick = 1'b0;
    cfg_we = 1'b0;
    cfg_phase_clr = 1'b0;
    check_eq("busy_after_round", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and constant core inputs
    check_eq("rst_angle", cor_angle, 32'd0);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_ch", out_ch, 2'd0);
    check_eq("rst_cos", out_cos, 16'd0);
    check_eq("rst_sin", out_sin, 16'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_overrun", {63'd0, overrun}, 64'd0);
    check_eq("x_start", cor_x_start, 16'd19891);
    check_eq("y_start", cor_y_start, 16'd0);

    // Quarter-turn steps on ch0, one tick every 8 cycles
    cfg_write(0, 32'h4000_0000, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      do_round(-1, -1, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
    end
    wait_drain();

    // All channels, steps 1..4: back-to-back results labelled 0..3
    do_reset();
    for (int i = 0; i < NCH; i++) cfg_write(i, 32'(i + 1), 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) do_round(-1, -1, 32'd0, 1'b0);
    wait_drain();

    // Natural wrap with step 0xFFFFFFFF
    do_reset();
    cfg_write(2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      do_round(-1, -1, 32'd0, 1'b0);
      @(negedge clk);
    end
    wait_drain();

    // Write with phase clear during ch1's slot
    do_reset();
    cfg_write(1, 32'h10, 1'b1, 1'b0);
    do_round(-1, -1, 32'd0, 1'b0);
    do_round(-1, 1, 32'h100, 1'b1);
    do_round(-1, -1, 32'd0, 1'b0);
    do_round(-1, -1, 32'd0, 1'b0);
    wait_drain();

    // Tick on the last ISSUE cycle and tick 2 cycles into a round: both dropped
    do_reset();
    check_eq("overrun_clear", {63'd0, overrun}, 64'd0);
    for (int i = 0; i < NCH; i++) cfg_write(i, 32'(i + 5), 1'b1, 1'b0);
    n0 = n_out;
    do_round(NCH - 1, -1, 32'd0, 1'b0);
    wait_drain();
    check_eq("overrun_last_cycle", {63'd0, overrun}, 64'd1);
    check_eq("outputs_last_cycle", n_out - n0, 4);
    n0 = n_out;
    do_round(1, -1, 32'd0, 1'b0);
    wait_drain();
    repeat (100) @(negedge clk);
    check_eq("overrun_sticky", {63'd0, overrun}, 64'd1);
    check_eq("outputs_overrun", n_out - n0, 4);

    // Reset mid-round with 3 tags in flight
    do_reset();
    for (int i = 0; i < NCH; i++) cfg_write(i, 32'h1000 * (i + 1), 1'b1, 1'b0);
    do_round(-1, -1, 32'd0, 1'b0);
    wait_drain();
    n0 = cyc;
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tick = 1'b0;
      check_eq("mid_angle", cor_angle, m_phase[k]);
      sb.push_back('{ch: 2'(k), cs: core_cos(m_phase[k]), sn: core_sin(m_phase[k]), due: n0 + 2 + k + LAT});
    end
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    n0 = n_out;
    repeat (2 * LAT) @(negedge clk);
    check_eq("no_stale_valid", n_out - n0, 0);
    check_eq("post_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("post_rst_overrun", {63'd0, overrun}, 64'd0);
    check_eq("post_rst_angle", cor_angle, 32'd0);
    do_round(-1, -1, 32'd0, 1'b0);
    repeat (LAT + 4) @(negedge clk);
    check_eq("disabled_no_output", n_out - n0, 0);

    wait_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_nco_sched.md
Name: cordic_nco_sched

Overview:
- Time-shares one pipelined CORDIC rotator core (DWIDTH-bit, fixed latency) among NCH independent NCO channels.
- Holds a per-channel 32-bit phase accumulator and step register, configured over a simple write port.
- On each sample tick, issues one angle per enabled channel to the core in round-robin order, and advances that channel's phase.
- Tags every issued angle so the returning cos/sin pair leaves the block labelled with its channel number.
- Sits between the control/register interface and the shared CORDIC core; it replaces the single-channel fixed-step generators.

Parameters:
NCH, 4, number of NCO channels (2..16)
DWIDTH, 16, CORDIC data width for x/y/cos/sin
PWIDTH, 32, phase accumulator and step width
CORDIC_LAT, 16, core latency in cycles from angle input to cos/sin output

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  sample strobe, one-cycle pulse; starts one issue round
cfg_we  in  1  config write strobe
cfg_ch  in  clog2(NCH)  channel addressed by the write
cfg_step  in  PWIDTH  new phase step for cfg_ch
cfg_en  in  1  new enable for cfg_ch
cfg_phase_clr  in  1  when set with cfg_we, clears phase of cfg_ch
cor_angle  out  PWIDTH  angle to the core; full scale 2^PWIDTH = 360 deg
cor_x_start  out  DWIDTH  constant COEF = (2^(DWIDTH-1) - (DWIDTH-1)/2) / 1.647, truncated
cor_y_start  out  DWIDTH  constant 0
cor_cos  in  DWIDTH signed  core cos output
cor_sin  in  DWIDTH signed  core sin output
out_valid  out  1  out_cos/out_sin/out_ch valid this cycle
out_ch  out  clog2(NCH)  channel of the current output
out_cos  out  DWIDTH signed  registered cos
out_sin  out  DWIDTH signed  registered sin
busy  out  1  high while the issue round is in progress
overrun  out  1  sticky; a tick arrived while busy

Behaviour:
Reset (asynchronous):
- All phase, step and enable registers go to 0.
- State returns to IDLE; the channel counter goes to 0.
- The tag pipeline is cleared, so no stale out_valid appears after reset, including a reset mid-round.
- Output reset values: cor_angle=0, out_valid=0, out_ch=0, out_cos=0, out_sin=0, busy=0, overrun=0.
FSM:
- IDLE: on tick, go to ISSUE with k=0 and busy=1.
- ISSUE: one slot per cycle, k = 0..NCH-1. After slot NCH-1, go back to IDLE.
- busy is high in every ISSUE cycle; a round always takes exactly NCH cycles.
Slot k:
- cor_angle = phase[k] (registered output) and the tag {valid=en[k], ch=k} enters the delay line.
- If en[k], then phase[k] <= phase[k] + step[k] mod 2^PWIDTH, wrapping naturally with no correction term.
- If en[k]=0, the slot is still consumed, cor_angle = phase[k], the tag valid bit is 0, and the phase is held.
Latency:
- Take a tick in cycle t. Channel k's angle is on cor_angle in cycle t+1+k.
- The core output for it is on cor_cos/cor_sin in cycle t+1+k+CORDIC_LAT.
- The registered result appears with out_valid=1 in cycle t+2+k+CORDIC_LAT.
- The tag delay line length is CORDIC_LAT+1.
Tick handling:
- A tick while busy is dropped and sets overrun=1. overrun clears only on rst.
- A tick arriving in the same cycle the FSM returns to IDLE is also dropped.
Configuration writes (all take effect on the next clock edge):
- A write lands at any time; step[cfg_ch] <= cfg_step and en[cfg_ch] <= cfg_en.
- Write in the same cycle as that channel's slot: the issued angle and the advance both use the old step and old enable. The new values apply from the next round.
- cfg_phase_clr=1: phase[cfg_ch] <= 0, and this takes priority over a same-cycle advance.
- Writes to other channels never disturb the slot in flight.
- out_cos/out_sin hold their last value while out_valid=0.

Decomposition:
- Package cordic_nco_pkg: COEF function of DWIDTH, the channel index width clog2(NCH), and the FSM state enum {IDLE, ISSUE}.
- One sub-module, cordic_tag_pipe: a parameterised shift register of depth CORDIC_LAT+1 that carries {valid, ch} with asynchronous clear.
- The phase/step register file and the FSM stay in the top module.

Test Plan:
- Reset, then ch0 step=0x40000000 enabled, ticks every 8 cycles -> ch0 angles 0, 0x40000000, 0x80000000, 0xC0000000, 0 on cor_angle; out_valid for ch0 exactly 2+CORDIC_LAT cycles after each tick.
- All 4 channels enabled with steps 1,2,3,4, one tick -> cor_angle shows ch0..ch3 in consecutive cycles; out_ch sequence 0,1,2,3 with 4 back-to-back out_valid pulses.
- ch2 step=0xFFFFFFFF, phase starting 0, 3 ticks -> issued angles 0, 0xFFFFFFFF, 0xFFFFFFFE (natural wrap).
- Second tick 2 cycles after the first (NCH=4) -> second tick ignored, overrun=1 and still 1 after 100 idle cycles; only 4 outputs produced.
- cfg write of ch1 step=0x100 with cfg_phase_clr=1 in the same cycle as ch1's slot -> issued angle uses the old phase; phase[1]=0 afterwards; next round issues angle 0, and the round after issues 0x100.
- rst asserted mid-round with 3 tags in flight -> out_valid stays 0 for the following 2*CORDIC_LAT cycles; busy=0 and all phases 0.
